// File: rtl/jmp_seq.sv
// jmp_seq: jump-instruction sequencer for the 8-bit CPU.
// When the decoder reports a jump, it fetches the two address operand bytes,
// high byte first, over a req/valid handshake. It then checks the branch
// condition against the flags captured at start and issues one PC-load pulse,
// carrying either the branch target or the skip address.
// Every output comes from a flop. Output values are computed from the next
// state, so each output lines up with the state it describes.
module jmp_seq #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  cins,
  input  logic [15:0] pc_in,
  input  logic        zflag,
  input  logic        oflag,
  input  logic        cflag,
  input  logic        sflag,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_rvalid,
  output logic        busy,
  output logic        pc_load,
  output logic [15:0] pc_next,
  output logic        taken,
  output logic        err
);

  // The wait counter must be wide enough to hold TIMEOUT - 1.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH_HI = 2'd1,
    FETCH_LO = 2'd2,
    RESOLVE  = 2'd3
  } state_t;

  state_t state_r, state_s;

  // Datapath registers and their next values.
  logic [7:0]    hi_r, hi_s;
  logic [7:0]    lo_r, lo_s;
  logic [15:0]   base_r, base_s;
  logic [3:0]    flags_r, flags_s;   // {z, o, c, s}, as captured at start
  logic [3:0]    cond_r, cond_s;
  logic          rel_r, rel_s;
  logic [CW-1:0] wait_r, wait_s;

  // Next values of the registered outputs.
  logic          mem_req_s;
  logic [15:0]   mem_addr_s;
  logic          busy_s;
  logic          pc_load_s;
  logic [15:0]   pc_next_s;
  logic          taken_s;
  logic          err_s;
  logic          wait_hit_s;

  // The opcode bits above the relative flag have no meaning for this block.
  logic unused_cins_s;
  assign unused_cins_s = ^cins[7:5];

  // Branch condition table. f = {z, o, c, s}. Selects 11 to 15 are never taken.
  function automatic logic cond_met(input logic [3:0] sel, input logic [3:0] f);
    logic z, o, c, s;
    z = f[3];
    o = f[2];
    c = f[1];
    s = f[0];
    case (sel)
      4'd0:    cond_met = 1'b1;
      4'd1:    cond_met = z;
      4'd2:    cond_met = ~z;
      4'd3:    cond_met = c;
      4'd4:    cond_met = c | z;
      4'd5:    cond_met = ~(c | z);
      4'd6:    cond_met = ~c;
      4'd7:    cond_met = o ^ s;
      4'd8:    cond_met = (o ^ s) | z;
      4'd9:    cond_met = ~(o ^ s);
      4'd10:   cond_met = (o ^ s) | ~z;
      default: cond_met = 1'b0;
    endcase
  endfunction

  // Fetch timeout: this wait cycle is the TIMEOUT-th cycle without rvalid.
  // A TIMEOUT of 0 disables the timeout.
  assign wait_hit_s = (TIMEOUT != 0) && (wait_r == CW'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic, datapath updates and next output values.
  always_comb begin
    state_s    = state_r;
    hi_s       = hi_r;
    lo_s       = lo_r;
    base_s     = base_r;
    flags_s    = flags_r;
    cond_s     = cond_r;
    rel_s      = rel_r;
    wait_s     = wait_r;
    err_s      = 1'b0;
    mem_req_s  = 1'b0;
    mem_addr_s = 16'h0000;
    busy_s     = 1'b0;
    pc_load_s  = 1'b0;
    pc_next_s  = 16'h0000;
    taken_s    = 1'b0;

    case (state_r)
      IDLE: begin
        if (start) begin
          base_s  = pc_in;
          cond_s  = cins[3:0];
          rel_s   = cins[4];
          flags_s = {zflag, oflag, cflag, sflag};
          wait_s  = {CW{1'b0}};
          state_s = FETCH_HI;
        end else begin
          state_s = IDLE;
        end
      end

      FETCH_HI: begin
        if (mem_rvalid) begin
          hi_s    = mem_rdata;
          wait_s  = {CW{1'b0}};
          state_s = FETCH_LO;
        end else if (wait_hit_s) begin
          err_s   = 1'b1;
          wait_s  = {CW{1'b0}};
          state_s = IDLE;
        end else if (TIMEOUT != 0) begin
          wait_s  = wait_r + CW'(1);
        end else begin
          wait_s  = wait_r;
        end
      end

      FETCH_LO: begin
        if (mem_rvalid) begin
          lo_s    = mem_rdata;
          wait_s  = {CW{1'b0}};
          state_s = RESOLVE;
        end else if (wait_hit_s) begin
          err_s   = 1'b1;
          wait_s  = {CW{1'b0}};
          state_s = IDLE;
        end else if (TIMEOUT != 0) begin
          wait_s  = wait_r + CW'(1);
        end else begin
          wait_s  = wait_r;
        end
      end

      RESOLVE: begin
        state_s = IDLE;
      end

      default: begin
        state_s = IDLE;
      end
    endcase

    // Output values for the state about to be entered.
    busy_s = (state_s != IDLE);

    case (state_s)
      FETCH_HI: begin
        mem_req_s  = 1'b1;
        mem_addr_s = base_s;
      end
      FETCH_LO: begin
        mem_req_s  = 1'b1;
        mem_addr_s = base_s + 16'd1;
      end
      RESOLVE: begin
        pc_load_s = 1'b1;
        taken_s   = cond_met(cond_s, flags_s);
        if (taken_s) begin
          if (rel_s) begin
            pc_next_s = base_s + {hi_s, lo_s};
          end else begin
            pc_next_s = {hi_s, lo_s};
          end
        end else begin
          pc_next_s = base_s + 16'd2;
        end
      end
      default: begin
        mem_req_s  = 1'b0;
        mem_addr_s = 16'h0000;
      end
    endcase
  end

  // Datapath registers: operand bytes, base PC, latched flags and opcode fields, wait counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_r    <= 8'h00;
      lo_r    <= 8'h00;
      base_r  <= 16'h0000;
      flags_r <= 4'h0;
      cond_r  <= 4'h0;
      rel_r   <= 1'b0;
      wait_r  <= {CW{1'b0}};
    end else begin
      hi_r    <= hi_s;
      lo_r    <= lo_s;
      base_r  <= base_s;
      flags_r <= flags_s;
      cond_r  <= cond_s;
      rel_r   <= rel_s;
      wait_r  <= wait_s;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req  <= 1'b0;
      mem_addr <= 16'h0000;
      busy     <= 1'b0;
      pc_load  <= 1'b0;
      pc_next  <= 16'h0000;
      taken    <= 1'b0;
      err      <= 1'b0;
    end else begin
      mem_req  <= mem_req_s;
      mem_addr <= mem_addr_s;
      busy     <= busy_s;
      pc_load  <= pc_load_s;
      pc_next  <= pc_next_s;
      taken    <= taken_s;
      err      <= err_s;
    end
  end

endmodule

// File: tb/tb_jmp_seq.sv
// tb_jmp_seq: directed self-checking bench for jmp_seq.
// Inputs are driven on the falling clock edge and outputs are sampled there too.
module tb_jmp_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  cins;
  logic [15:0] pc_in;
  logic        zflag, oflag, cflag, sflag;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        mem_rvalid;
  logic        busy;
  logic        pc_load;
  logic [15:0] pc_next;
  logic        taken;
  logic        err;

  int vec_cnt = 0;
  int err_cnt = 0;

  jmp_seq #(.TIMEOUT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cins       (cins),
    .pc_in      (pc_in),
    .zflag      (zflag),
    .oflag      (oflag),
    .cflag      (cflag),
    .sflag      (sflag),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .busy       (busy),
    .pc_load    (pc_load),
    .pc_next    (pc_next),
    .taken      (taken),
    .err        (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  // Reference condition table. f = {z, o, c, s}.
  function automatic logic model_cond(input logic [3:0] sel, input logic [3:0] f);
    logic z, o, c, s;
    z = f[3]; o = f[2]; c = f[1]; s = f[0];
    case (sel)
      4'd0:    model_cond = 1'b1;
      4'd1:    model_cond = z;
      4'd2:    model_cond = !z;
      4'd3:    model_cond = c;
      4'd4:    model_cond = c || z;
      4'd5:    model_cond = !(c || z);
      4'd6:    model_cond = !c;
      4'd7:    model_cond = o != s;
      4'd8:    model_cond = (o != s) || z;
      4'd9:    model_cond = o == s;
      4'd10:   model_cond = (o != s) || !z;
      default: model_cond = 1'b0;
    endcase
  endfunction

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_busy"},    busy,     16'd0);
    check_eq({tag, "_req"},     mem_req,  16'd0);
    check_eq({tag, "_addr"},    mem_addr, 16'd0);
    check_eq({tag, "_load"},    pc_load,  16'd0);
    check_eq({tag, "_pcnext"},  pc_next,  16'd0);
    check_eq({tag, "_taken"},   taken,    16'd0);
    check_eq({tag, "_err"},     err,      16'd0);
  endtask

  // One complete jump. Waits wh and wl add cycles without rvalid to the fetches.
  // The flags are inverted after start, so the decision must use the latched copy.
  task automatic run_jump(input logic [7:0] c, input logic [15:0] pc,
                          input logic [7:0] hb, input logic [7:0] lb,
                          input logic [3:0] f, input int wh, input int wl,
                          input logic expect_taken, input logic [15:0] expect_pc);
    logic [15:0] pc1;
    pc1 = pc + 16'd1;
    cins  = c;
    pc_in = pc;
    {zflag, oflag, cflag, sflag} = f;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    {zflag, oflag, cflag, sflag} = ~f;
    cins  = 8'hFF;
    pc_in = 16'hDEAD;
    for (int i = 0; i <= wh; i++) begin
      check_eq("hi_req",  mem_req,  16'd1);
      check_eq("hi_addr", mem_addr, pc);
      check_eq("hi_busy", busy,     16'd1);
      mem_rvalid = (i == wh);
      mem_rdata  = (i == wh) ? hb : 8'hA5;
      @(negedge clk);
    end
    for (int i = 0; i <= wl; i++) begin
      check_eq("lo_req",  mem_req,  16'd1);
      check_eq("lo_addr", mem_addr, pc1);
      check_eq("lo_load", pc_load,  16'd0);
      mem_rvalid = (i == wl);
      mem_rdata  = (i == wl) ? lb : 8'h5A;
      @(negedge clk);
    end
    // This is the resolve cycle. The bench asserts a stray rvalid here, and the design must ignore it.
    mem_rvalid = 1'b1;
    mem_rdata  = 8'h3C;
    check_eq("res_load",   pc_load, 16'd1);
    check_eq("res_busy",   busy,    16'd1);
    check_eq("res_req",    mem_req, 16'd0);
    check_eq("res_taken",  taken,   {15'd0, expect_taken});
    check_eq("res_pcnext", pc_next, expect_pc);
    @(negedge clk);
    mem_rvalid = 1'b0;
    check_eq("post_load",   pc_load, 16'd0);
    check_eq("post_busy",   busy,    16'd0);
    check_eq("post_pcnext", pc_next, 16'd0);
    check_eq("post_taken",  taken,   16'd0);
  endtask

  // Watchdog: every loop in the bench is bounded, so this only triggers if the simulation stalls.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        et;
    logic [15:0] ep;
    rst = 1'b1; start = 1'b0; cins = 8'h00; pc_in = 16'h0000;
    zflag = 1'b0; oflag = 1'b0; cflag = 1'b0; sflag = 1'b0;
    mem_rdata = 8'h00; mem_rvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Unconditional absolute jump with no wait states.
    run_jump(8'h00, 16'h1234, 8'h56, 8'h78, 4'b0000, 0, 0, 1'b1, 16'h5678);

    // Jump-if-zero with z clear at start. z rises during the fetch, and the jump must still skip.
    run_jump(8'h01, 16'h1234, 8'h56, 8'h78, 4'b0000, 0, 0, 1'b0, 16'h1236);

    // Relative jump whose target wraps: 0xFFF0 + 0x0020 = 0x0010.
    run_jump(8'h10, 16'hFFF0, 8'h00, 8'h20, 4'b0000, 0, 0, 1'b1, 16'h0010);

    // Operand address wrap: reads at 0xFFFF then 0x0000. Never taken, so skip to 0x0001.
    run_jump(8'h0B, 16'hFFFF, 8'h12, 8'h34, 4'b1111, 0, 0, 1'b0, 16'h0001);

    // Wait states in both fetches, taken relative jump: 0x0100 + 0x0203 = 0x0303.
    run_jump(8'h10, 16'h0100, 8'h02, 8'h03, 4'b0000, 2, 1, 1'b1, 16'h0303);

    // Condition sweep: every select against every flag combination.
    for (int sel = 0; sel < 16; sel++) begin
      for (int f = 0; f < 16; f++) begin
        et = model_cond(4'(sel), 4'(f));
        ep = et ? 16'h1234 : 16'h2002;
        run_jump({4'h0, 4'(sel)}, 16'h2000, 8'h12, 8'h34, 4'(f), 0, 0, et, ep);
      end
    end

    // Timeout in the low-byte fetch. A start pulsed while busy must be ignored.
    cins = 8'h00; pc_in = 16'h3000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("to_hi_addr", mem_addr, 16'h3000);
    mem_rvalid = 1'b1; mem_rdata = 8'h11;
    @(negedge clk);
    mem_rvalid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      check_eq("to_busy", busy,     16'd1);
      check_eq("to_addr", mem_addr, 16'h3001);
      check_eq("to_load", pc_load,  16'd0);
      check_eq("to_err",  err,      16'd0);
      start = (k == 5);
      pc_in = (k == 5) ? 16'h5000 : 16'h3000;
      @(negedge clk);
    end
    start = 1'b0;
    check_eq("to_err_pulse", err,     16'd1);
    check_eq("to_idle",      busy,    16'd0);
    check_eq("to_noload",    pc_load, 16'd0);
    check_eq("to_noreq",     mem_req, 16'd0);
    @(negedge clk);
    check_eq("to_err_end",   err,     16'd0);
    check_eq("to_noqueue",   busy,    16'd0);
    @(negedge clk);
    check_eq("to_noqueue2",  busy,    16'd0);

    // Asynchronous reset during the low-byte fetch, in its third wait cycle.
    cins = 8'h00; pc_in = 16'h6000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 8'h22;
    @(negedge clk);
    mem_rvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_pre_busy", busy, 16'd1);
    rst = 1'b1;
    #1;
    check_idle_outputs("rst_async");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("rst_after");

    // After the reset, a new jump must complete normally.
    run_jump(8'h00, 16'h7000, 8'h9A, 8'hBC, 4'b0000, 1, 2, 1'b1, 16'h9ABC);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
